// File: rtl/ball_crash_detect.sv
// ball_crash_detect
//   Turns ball and paddle positions into the crash vector used by the ball
//   mover. It also detects misses at the left and right edges and keeps each
//   player's score and the game-over state.
// Ports:
//   iVGA_CLK, iRST_n       pixel clock; asynchronous active-low reset
//   iBall_x, iBall_y       ball top-left corner
//   iPaddleL_y, iPaddleR_y paddle top y positions
//   iRestart               synchronous pulse: clear scores, resume play
//   oCrash                 {left,right,up,down} registered one-cycle pulses
//   oMissL, oMissR         one-cycle pulse on entering the left/right edge zone
//   oScoreL, oScoreR       player scores
//   oGameOver              high while the game is over
module ball_crash_detect #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int BALL_SIZE      = 8,
  parameter int PADDLE_W       = 8,
  parameter int PADDLE_H       = 64,
  parameter int LEFT_PADDLE_X  = 16,
  parameter int RIGHT_PADDLE_X = 616,
  parameter int HOLDOFF        = 4,
  parameter int SCORE_MAX      = 9
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [9:0] iBall_x,
  input  logic [9:0] iBall_y,
  input  logic [9:0] iPaddleL_y,
  input  logic [9:0] iPaddleR_y,
  input  logic       iRestart,
  output logic [3:0] oCrash,
  output logic       oMissL,
  output logic       oMissR,
  output logic [3:0] oScoreL,
  output logic [3:0] oScoreR,
  output logic       oGameOver
);

  localparam logic [0:0] PLAY = 1'b0;
  localparam logic [0:0] OVER = 1'b1;

  localparam logic [10:0] C_SW    = 11'(SCREEN_W);
  localparam logic [10:0] C_SH    = 11'(SCREEN_H);
  localparam logic [10:0] C_BALL  = 11'(BALL_SIZE);
  localparam logic [10:0] C_PH    = 11'(PADDLE_H);
  localparam logic [10:0] C_LX    = 11'(LEFT_PADDLE_X);
  localparam logic [10:0] C_LX_W  = 11'(LEFT_PADDLE_X + PADDLE_W);
  localparam logic [10:0] C_RX    = 11'(RIGHT_PADDLE_X);
  localparam logic [10:0] C_RX_W  = 11'(RIGHT_PADDLE_X + PADDLE_W);
  localparam logic [7:0]  C_HOLD  = 8'(HOLDOFF);
  localparam logic [3:0]  C_SMAX  = 4'(SCORE_MAX);

  logic [0:0] state;
  logic [7:0] hold_cnt [4];
  logic       zl_q, zr_q;

  logic [10:0] x11, y11, x_end, y_end, pl11, pr11;
  logic        ovl_l, ovl_r, pad_l, pad_r;
  logic        zone_l, zone_r;
  logic [3:0]  raw;
  logic [3:0]  inc_l, inc_r;

  always_comb begin
    x11   = {1'b0, iBall_x};
    y11   = {1'b0, iBall_y};
    pl11  = {1'b0, iPaddleL_y};
    pr11  = {1'b0, iPaddleR_y};
    x_end = x11 + C_BALL;
    y_end = y11 + C_BALL;
    ovl_l = (y_end > pl11) && (y11 < pl11 + C_PH);
    ovl_r = (y_end > pr11) && (y11 < pr11 + C_PH);
    pad_l = (x11 <= C_LX_W) && (x_end > C_LX) && ovl_l;
    pad_r = (x_end >= C_RX) && (x11 < C_RX_W) && ovl_r;
    zone_l = (iBall_x == 10'd0);
    zone_r = (x_end >= C_SW);
    // Paddles only count while playing; walls keep bouncing the ball in OVER.
    raw[3] = zone_l | (pad_l & (state == PLAY));
    raw[2] = zone_r | (pad_r & (state == PLAY));
    raw[1] = (iBall_y == 10'd0);
    raw[0] = (y_end >= C_SH);
    inc_l  = oScoreL + 4'd1;
    inc_r  = oScoreR + 4'd1;
  end

  // Crash pulses with per-bit holdoff, plus edge-zone miss detection.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oCrash <= '0;
      oMissL <= 1'b0;
      oMissR <= 1'b0;
      zl_q   <= 1'b0;
      zr_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) hold_cnt[i] <= '0;
    end else if (iRestart) begin
      oCrash <= '0;
      oMissL <= 1'b0;
      oMissR <= 1'b0;
      zl_q   <= 1'b0;
      zr_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) hold_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (hold_cnt[i] != 8'd0) begin
          oCrash[i]   <= 1'b0;
          hold_cnt[i] <= hold_cnt[i] - 8'd1;
        end else begin
          oCrash[i] <= raw[i];
          if (raw[i]) hold_cnt[i] <= C_HOLD;
        end
      end
      zl_q   <= zone_l;
      zr_q   <= zone_r;
      oMissL <= zone_l & ~zl_q;
      oMissR <= zone_r & ~zr_q;
    end
  end

  // Scores follow the registered miss pulses, so they update one cycle later.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= PLAY;
      oScoreL <= '0;
      oScoreR <= '0;
    end else if (iRestart) begin
      state   <= PLAY;
      oScoreL <= '0;
      oScoreR <= '0;
    end else if (state == PLAY) begin
      if (oMissL) oScoreR <= inc_r;
      if (oMissR) oScoreL <= inc_l;
      if ((oMissL && inc_r == C_SMAX) || (oMissR && inc_l == C_SMAX))
        state <= OVER;
    end
  end

  assign oGameOver = (state == OVER);

endmodule

// File: tb/tb_ball_crash_detect.sv
module tb_ball_crash_detect;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] bx, by, pl, pr;
  logic       restart;
  logic [3:0] crash;
  logic       miss_l, miss_r;
  logic [3:0] score_l, score_r;
  logic       game_over;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ball_crash_detect dut (
    .iVGA_CLK   (clk),
    .iRST_n     (rst_n),
    .iBall_x    (bx),
    .iBall_y    (by),
    .iPaddleL_y (pl),
    .iPaddleR_y (pr),
    .iRestart   (restart),
    .oCrash     (crash),
    .oMissL     (miss_l),
    .oMissR     (miss_r),
    .oScoreL    (score_l),
    .oScoreR    (score_r),
    .oGameOver  (game_over)
  );

  typedef struct {
    string      name;
    logic [9:0] x, y, pyl, pyr;
    logic [3:0] crash;
    logic       ml, mr;
  } vec_t;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    bx = 10'd300; by = 10'd200; restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic left_entry();
    bx = 10'd0; tick();
    bx = 10'd100; tick();
  endtask

  task automatic right_entry();
    bx = 10'd632; tick();
    bx = 10'd100; tick();
  endtask

  vec_t vecs [$];

  initial begin
    vecs.push_back('{"paddleL_hit",    10'd24,  10'd100, 10'd80,  10'd80,  4'b1000, 1'b0, 1'b0});
    vecs.push_back('{"paddleL_noovl",  10'd24,  10'd100, 10'd200, 10'd80,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"corner_rd",      10'd632, 10'd472, 10'd80,  10'd80,  4'b0101, 1'b0, 1'b1});
    vecs.push_back('{"corner_lu",      10'd0,   10'd0,   10'd80,  10'd80,  4'b1010, 1'b1, 1'b0});
    vecs.push_back('{"top_wall",       10'd300, 10'd0,   10'd80,  10'd80,  4'b0010, 1'b0, 1'b0});
    vecs.push_back('{"bottom_wall",    10'd300, 10'd472, 10'd80,  10'd80,  4'b0001, 1'b0, 1'b0});
    vecs.push_back('{"bottom_minus1",  10'd300, 10'd471, 10'd80,  10'd80,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"paddleR_hit",    10'd608, 10'd100, 10'd80,  10'd80,  4'b0100, 1'b0, 1'b0});
    vecs.push_back('{"paddleR_short",  10'd607, 10'd100, 10'd80,  10'd80,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"paddleR_past",   10'd624, 10'd100, 10'd80,  10'd300, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"right_minus1",   10'd631, 10'd100, 10'd80,  10'd300, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"paddleL_past",   10'd25,  10'd100, 10'd80,  10'd80,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"paddleL_short",  10'd8,   10'd100, 10'd80,  10'd80,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"paddleL_front",  10'd9,   10'd100, 10'd80,  10'd80,  4'b1000, 1'b0, 1'b0});
    vecs.push_back('{"ovl_above",      10'd24,  10'd72,  10'd80,  10'd80,  4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"ovl_top_edge",   10'd24,  10'd73,  10'd80,  10'd80,  4'b1000, 1'b0, 1'b0});
    vecs.push_back('{"ovl_bot_edge",   10'd24,  10'd143, 10'd80,  10'd80,  4'b1000, 1'b0, 1'b0});
    vecs.push_back('{"ovl_below",      10'd24,  10'd144, 10'd80,  10'd80,  4'b0000, 1'b0, 1'b0});

    rst_n = 1'b0; restart = 1'b0;
    bx = 10'd100; by = 10'd100; pl = 10'd80; pr = 10'd80;
    #12;
    check("reset_crash", {4'h0, crash}, 8'h00);
    check("reset_miss", {6'h0, miss_l, miss_r}, 8'h00);
    check("reset_scores", {score_l, score_r}, 8'h00);
    check("reset_over", {7'h0, game_over}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("idle_crash", {4'h0, crash}, 8'h00);

    // Left edge: pulse, holdoff of 4, re-pulse, single miss.
    bx = 10'd0;
    tick();
    check("edgeL_crash", {4'h0, crash}, 8'h08);
    check("edgeL_miss", {7'h0, miss_l}, 8'h01);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("holdoff_%0d", k), {4'h0, crash}, 8'h00);
      check($sformatf("no_remiss_%0d", k), {7'h0, miss_l}, 8'h00);
      if (k == 1) check("scoreR_1", {4'h0, score_r}, 8'h01);
    end
    tick();
    check("repulse", {4'h0, crash}, 8'h08);
    check("repulse_nomiss", {7'h0, miss_l}, 8'h00);

    // Table-driven single-cycle vectors, each from a clean restart.
    foreach (vecs[i]) begin
      do_restart();
      bx = vecs[i].x; by = vecs[i].y; pl = vecs[i].pyl; pr = vecs[i].pyr;
      tick();
      check({vecs[i].name, "_crash"}, {4'h0, crash}, {4'h0, vecs[i].crash});
      check({vecs[i].name, "_miss"}, {6'h0, miss_l, miss_r}, {6'h0, vecs[i].ml, vecs[i].mr});
    end
    pl = 10'd80; pr = 10'd80;

    // Corner miss scores for the left player.
    do_restart();
    by = 10'd472;
    right_entry();
    check("corner_scoreL", {score_l, score_r}, 8'h10);
    by = 10'd100;

    // Game over after nine left-edge misses.
    do_restart();
    for (int n = 0; n < 9; n++) left_entry();
    check("over_scoreR", {4'h0, score_r}, 8'h09);
    check("over_flag", {7'h0, game_over}, 8'h01);
    bx = 10'd0; tick();
    check("over_miss", {7'h0, miss_l}, 8'h01);
    bx = 10'd100; tick();
    check("over_frozen", {4'h0, score_r}, 8'h09);
    for (int n = 0; n < 5; n++) tick();
    bx = 10'd24; by = 10'd100; tick();
    check("over_paddle", {4'h0, crash}, 8'h00);
    bx = 10'd300; by = 10'd0; tick();
    check("over_wall", {4'h0, crash}, 8'h02);
    by = 10'd100;
    for (int n = 0; n < 5; n++) tick();
    restart = 1'b1; tick(); restart = 1'b0;
    check("restart_scores", {score_l, score_r}, 8'h00);
    check("restart_over", {7'h0, game_over}, 8'h00);

    // Async reset during holdoff with scores 3/5.
    for (int n = 0; n < 5; n++) left_entry();
    for (int n = 0; n < 3; n++) right_entry();
    check("pre_scores", {score_l, score_r}, 8'h35);
    bx = 10'd0; tick();
    check("pre_crash", {4'h0, crash}, 8'h08);
    #3 rst_n = 1'b0;
    #1;
    check("async_crash", {4'h0, crash}, 8'h00);
    check("async_miss", {6'h0, miss_l, miss_r}, 8'h00);
    check("async_scores", {score_l, score_r}, 8'h00);
    check("async_over", {7'h0, game_over}, 8'h00);
    bx = 10'd0; by = 10'd0;
    #2 rst_n = 1'b1;
    tick();
    check("post_reset_crash", {4'h0, crash}, 8'h0A);
    check("post_reset_miss", {7'h0, miss_l}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
